max_pool: RTL and testbench
===========================

MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width (signed Q16.16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, DRAM word-address width.
REQ-003 SHALL have parameter IN_BASE, default 18'd131072, base of the 10x10x16 input feature map.
REQ-004 SHALL have parameter OUT_BASE, default 18'd65536, base of the 5x5x16 pooled output.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port srstn, input, 1, reset (synchronous, active-low).
REQ-007 SHALL have port enable, input, 1, start request, sampled in IDLE.
REQ-008 SHALL have port dram_valid, input, 1, kept for port compatibility and ignored.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, DRAM read data.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, DRAM write data.
REQ-011 SHALL have port addr_in, output, ADDR_WIDTH, DRAM read address.
REQ-012 SHALL have port addr_out, output, ADDR_WIDTH, DRAM write address.
REQ-013 SHALL have port dram_en_rd, output, 1, read strobe.
REQ-014 SHALL have port dram_en_wr, output, 1, write strobe.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement one-hot FSM states IDLE, RD, WAIT, WR, DONE.
REQ-017 SHALL transition IDLE->RD on enable, RD->WAIT after 4 cycles, WAIT->WR, WR->RD (more windows) or WR->DONE (last window), DONE->IDLE unconditionally.
REQ-018 SHALL handle DRAM read latency as 1 cycle: data_in for addr_in at cycle t is valid at cycle t+1.
REQ-019 SHALL, in RD, present window elements in order (2y,2x), (2y,2x+1), (2y+1,2x), (2y+1,2x+1), with addr_in = IN_BASE + z*100 + row*10 + col.
REQ-020 SHALL load the running max directly from the first element of each window (no compare against prior value); later elements update it when signed data_in > max.
REQ-021 SHALL capture the fourth element during WAIT.
REQ-022 SHALL, in WR only, assert dram_en_wr for one cycle with addr_out = OUT_BASE + z*25 + y*5 + x and data_out = pooled max.
REQ-023 SHALL iterate output x fastest (0..4), then y (0..4), then z (0..15); counters wrap to 0 after the last window.
REQ-024 SHALL assert dram_en_rd only in RD; addr_in, addr_out and data_out SHALL be 0 outside RD/WR respectively.
REQ-025 SHALL take 6 cycles per window; done SHALL rise exactly 2401 cycles after the cycle enable is sampled high in IDLE, after exactly 400 writes.
REQ-026 SHALL ignore enable outside IDLE; enable held high SHALL restart a new pass on the cycle after DONE.
REQ-027 SHALL treat equal values as no update (result identical either way).

Reset
REQ-028 SHALL, when srstn=0 at a clock edge, enter IDLE and clear all counters and the max register, including mid-pass.
REQ-029 SHALL drive done, dram_en_rd, dram_en_wr, addr_in, addr_out and data_out to 0 in the cycle after reset; no partial window SHALL be written.

Configuration
REQ-030 SHALL, with macro POOL_RELU_EN defined, write max(pooled,0) (negative results clamped to 0).
REQ-031 SHALL, without POOL_RELU_EN, write the raw signed pooled max.

Verification
REQ-032 SHALL cover ramp input: input[i] = i<<16 -> first write addr 65536 data 11<<16; last write addr 65935 data 1599<<16.
REQ-033 SHALL cover a negative window: window 0 = {-3,-1,-7,-2}<<16 -> data_out 0xFFFF0000 without macro, 0 with POOL_RELU_EN.
REQ-034 SHALL cover timing: single-cycle enable -> exactly 400 dram_en_wr pulses, 4 reads per write, done at cycle 2401, done high 1 cycle.
REQ-035 SHALL cover reset: srstn low at cycle 100 -> all outputs 0 next cycle, FSM IDLE; re-enable yields a full 400-write pass from addr 65536.
REQ-036 SHALL cover continuous enable -> second pass starts the cycle after done, identical write sequence.

Source files
------------

// File: rtl/max_pool.sv
// 2x2 stride-2 max pooling of a 10x10x16 Q16.16 feature map in DRAM into 5x5x16.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero before writeback.
module max_pool #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE    = 18'd131072,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = 18'd65536
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam int unsigned XY_LAST = 4;
  localparam int unsigned Z_LAST  = 15;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RD   = 5'b00010,
    WAIT = 5'b00100,
    WR   = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              x_q, x_d, y_q, y_d;
  logic [3:0]              z_q, z_d;
  logic [1:0]              rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   data_out_d;
  logic [ADDR_WIDTH-1:0]   addr_in_d, addr_out_d;
  logic                    dram_en_rd_d, dram_en_wr_d, done_d;
  logic                    gt_c;
  logic [3:0]              row_c, col_c;
  logic [DATA_WIDTH-1:0]   pool_c;
  logic                    unused_dram_valid;

  assign unused_dram_valid = dram_valid;
  assign gt_c = $signed(data_in) > $signed(max_q);

  // Next state, window counters and running max; data_in trails addr_in by one cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    rd_cnt_d = rd_cnt_q;
    max_d    = max_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = RD;
          rd_cnt_d = 2'd0;
        end
      end
      RD: begin
        if (rd_cnt_q == 2'd1) begin
          max_d = data_in;
        end else if (rd_cnt_q != 2'd0 && gt_c) begin
          max_d = data_in;
        end
        if (rd_cnt_q == 2'd3) begin
          state_d = WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      WAIT: begin
        if (gt_c) begin
          max_d = data_in;
        end
        state_d = WR;
      end
      WR: begin
        rd_cnt_d = 2'd0;
        if (x_q != 3'(XY_LAST)) begin
          x_d     = x_q + 3'd1;
          state_d = RD;
        end else begin
          x_d = 3'd0;
          if (y_q != 3'(XY_LAST)) begin
            y_d     = y_q + 3'd1;
            state_d = RD;
          end else begin
            y_d = 3'd0;
            if (z_q != 4'(Z_LAST)) begin
              z_d     = z_q + 4'd1;
              state_d = RD;
            end else begin
              z_d     = 4'd0;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they belong to.
  always_comb begin
    row_c = {y_d, 1'b0} + 4'(rd_cnt_d[1]);
    col_c = {x_d, 1'b0} + 4'(rd_cnt_d[0]);
`ifdef POOL_RELU_EN
    pool_c = max_d[DATA_WIDTH-1] ? '0 : max_d;
`else
    pool_c = max_d;
`endif
    dram_en_rd_d = (state_d == RD);
    dram_en_wr_d = (state_d == WR);
    done_d       = (state_d == DONE);
    addr_in_d    = '0;
    addr_out_d   = '0;
    data_out_d   = '0;
    if (dram_en_rd_d) begin
      addr_in_d = IN_BASE + ADDR_WIDTH'(z_d) * ADDR_WIDTH'(100)
                + ADDR_WIDTH'(row_c) * ADDR_WIDTH'(10) + ADDR_WIDTH'(col_c);
    end
    if (dram_en_wr_d) begin
      addr_out_d = OUT_BASE + ADDR_WIDTH'(z_d) * ADDR_WIDTH'(25)
                 + ADDR_WIDTH'(y_d) * ADDR_WIDTH'(5) + ADDR_WIDTH'(x_d);
      data_out_d = pool_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      rd_cnt_q   <= '0;
      max_q      <= '0;
      data_out   <= '0;
      addr_in    <= '0;
      addr_out   <= '0;
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      rd_cnt_q   <= rd_cnt_d;
      max_q      <= max_d;
      data_out   <= data_out_d;
      addr_in    <= addr_in_d;
      addr_out   <= addr_out_d;
      dram_en_rd <= dram_en_rd_d;
      dram_en_wr <= dram_en_wr_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_max_pool.sv
// Self-checking bench for max_pool: DRAM model, per-cycle output checks against a window-max model.
module tb_max_pool;

  localparam int IN_BASE  = 131072;
  localparam int OUT_BASE = 65536;

  logic        clk = 1'b0;
  logic        srstn, enable, dram_valid;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [17:0] addr_in, addr_out;
  logic        dram_en_rd, dram_en_wr, done;

  logic [31:0] mem [0:1599];
  int cyc = 0;
  int checks = 0, errors = 0;
  int rd_idx, wr_idx, rd_since, done_cnt, done_cyc, c0;
  logic [31:0] first_wr_data, last_wr_data;
  logic [17:0] first_wr_addr, last_wr_addr;

  max_pool dut (
    .clk(clk), .srstn(srstn), .enable(enable), .dram_valid(dram_valid),
    .data_in(data_in), .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency DRAM read port
  always @(posedge clk) begin
    if (int'(addr_in) >= IN_BASE && int'(addr_in) < IN_BASE + 1600)
      data_in <= mem[int'(addr_in) - IN_BASE];
    else
      data_in <= 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] exp_rd_addr(input int r);
    int w, e, x, y, z;
    w = (r % 1600) / 4; e = r % 4;
    x = w % 5; y = (w / 5) % 5; z = w / 25;
    return 18'(IN_BASE + z * 100 + (2 * y + e / 2) * 10 + 2 * x + e % 2);
  endfunction

  function automatic logic [31:0] exp_wr_data(input int w);
    int x, y, z, b;
    logic signed [31:0] m, v;
    x = w % 5; y = (w / 5) % 5; z = w / 25;
    b = z * 100 + y * 20 + x * 2;
    m = $signed(mem[b]);
    v = $signed(mem[b + 1]);  if (v > m) m = v;
    v = $signed(mem[b + 10]); if (v > m) m = v;
    v = $signed(mem[b + 11]); if (v > m) m = v;
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // Advance one cycle and check every output against the model at the falling edge
  task automatic tick();
    @(negedge clk);
    if (dram_en_rd) begin
      chk("rd_addr", addr_in, exp_rd_addr(rd_idx));
      rd_idx++; rd_since++;
    end else begin
      chk("addr_in_idle", addr_in, 0);
    end
    if (dram_en_wr) begin
      chk("wr_addr", addr_out, 18'(OUT_BASE + wr_idx % 400));
      chk("wr_data", data_out, exp_wr_data(wr_idx % 400));
      chk("reads_per_write", rd_since, 4);
      if (wr_idx == 0) begin first_wr_data = data_out; first_wr_addr = addr_out; end
      if (wr_idx == 399) begin last_wr_data = data_out; last_wr_addr = addr_out; end
      rd_since = 0;
      wr_idx++;
    end else begin
      chk("addr_out_idle", addr_out, 0);
      chk("data_out_idle", data_out, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic begin_pass();
    rd_idx = 0; wr_idx = 0; rd_since = 0; done_cnt = 0; done_cyc = 0; c0 = cyc;
    first_wr_data = 'x; last_wr_data = 'x; first_wr_addr = 'x; last_wr_addr = 'x;
  endtask

  task automatic finish_pass(input bit drop_en);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      tick();
      if (drop_en) enable = 1'b0;
    end
    chk("done_seen", done_cnt, 1);
    chk("done_cycle", done_cyc - c0, 2401);
    chk("wr_count", wr_idx, 400);
    chk("rd_count", rd_idx, 1600);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 1600; i++) mem[i] = 32'(i) << 16;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en_rd"}, dram_en_rd, 0);
    chk({tag, "_en_wr"}, dram_en_wr, 0);
    chk({tag, "_addr_in"}, addr_in, 0);
    chk({tag, "_addr_out"}, addr_out, 0);
    chk({tag, "_data_out"}, data_out, 0);
  endtask

  initial begin
    srstn = 1'b0; enable = 1'b0; dram_valid = 1'b0;
    load_ramp();
    begin_pass();
    tick(); tick();
    check_all_zero("reset");
    srstn = 1'b1;
    tick();
    check_all_zero("idle");

    // Ramp pass with a single-cycle enable
    enable = 1'b1;
    begin_pass();
    finish_pass(1'b1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("ramp_first_addr", first_wr_addr, 18'd65536);
    chk("ramp_first_data", first_wr_data, 32'h000B_0000);
    chk("ramp_last_addr", last_wr_addr, 18'd65935);
    chk("ramp_last_data", last_wr_data, 32'h063F_0000);

    // Negative window 0: {-3,-1,-7,-2} in Q16.16
    mem[0]  = 32'hFFFD_0000;
    mem[1]  = 32'hFFFF_0000;
    mem[10] = 32'hFFF9_0000;
    mem[11] = 32'hFFFE_0000;
    dram_valid = 1'b1;
    enable = 1'b1;
    begin_pass();
    finish_pass(1'b1);
`ifdef POOL_RELU_EN
    chk("neg_window", first_wr_data, 32'h0000_0000);
`else
    chk("neg_window", first_wr_data, 32'hFFFF_0000);
`endif
    dram_valid = 1'b0;
    tick();

    // Reset mid-pass, then a clean full pass
    load_ramp();
    enable = 1'b1;
    begin_pass();
    repeat (100) begin
      tick();
      enable = 1'b0;
    end
    srstn = 1'b0;
    tick();
    check_all_zero("midreset");
    srstn = 1'b1;
    begin_pass();
    repeat (5) begin
      tick();
      chk("post_reset_idle_rd", dram_en_rd, 0);
    end
    enable = 1'b1;
    begin_pass();
    finish_pass(1'b1);
    chk("rerun_first_addr", first_wr_addr, 18'd65536);
    chk("rerun_first_data", first_wr_data, 32'h000B_0000);
    tick();

    // Continuous enable: back-to-back passes through one IDLE cycle
    enable = 1'b1;
    begin_pass();
    finish_pass(1'b0);
    tick();
    chk("cont_done_low", done, 0);
    chk("cont_idle_rd", dram_en_rd, 0);
    begin_pass();
    finish_pass(1'b0);
    chk("cont2_last_data", last_wr_data, 32'h063F_0000);
    enable = 1'b0;
    tick();
    chk("cont2_done_low", done, 0);
    repeat (3) begin
      tick();
      chk("final_idle_rd", dram_en_rd, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
